// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM state and forward-select encodings
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } fsm_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // M-stage result is newer than W, so it wins when both match
    function automatic fwd_sel_e fwd_select(input logic match_m, input logic wr_m,
                                            input logic match_w, input logic wr_w);
        if (match_m && wr_m)
            return FWD_M;
        else if (match_w && wr_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline hazard signal bundle
interface hazard_controller_if;

    logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic        RegWriteM, RegWriteW, MemtoRegE;
    logic        PCWrPendingF, BranchTakenE, PCSrcW;
    logic        MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        MemTimeoutErr;
    logic [15:0] StallCount, FlushCount;

    modport master (
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemtoRegE,
        output PCWrPendingF, BranchTakenE, PCSrcW,
        output MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  MemTimeoutErr, StallCount, FlushCount
    );

    modport slave (
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemtoRegE,
        input  PCWrPendingF, BranchTakenE, PCSrcW,
        input  MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output MemTimeoutErr, StallCount, FlushCount
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, stall/flush control and memory-wait watchdog
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    hazard_controller_if.slave hz
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    logic       ldr_stall, mem_stall;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    fwd_sel_e   fwd_a, fwd_b;

    fsm_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    assign ldr_stall = hz.Match_12D_E & hz.MemtoRegE;
    assign mem_stall = hz.MemReqM & ~hz.MemReadyM;

    always_comb begin
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!reset) begin
            fwd_a = fwd_select(hz.Match_1E_M, hz.RegWriteM, hz.Match_1E_W, hz.RegWriteW);
            fwd_b = fwd_select(hz.Match_2E_M, hz.RegWriteM, hz.Match_2E_W, hz.RegWriteW);
            if (mem_stall) begin
                // freeze F..M and bubble W; redirects wait until memory completes
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = ldr_stall | hz.PCWrPendingF;
                stall_d = ldr_stall;
                flush_d = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
                flush_e = ldr_stall | hz.BranchTakenE;
            end
            // the W-stage PC write must always land in F
            if (hz.PCSrcW)
                stall_f = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q | (wait_q == WAIT_MAX);
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEMWAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEMWAIT: begin
                if (hz.MemReadyM || !hz.MemReqM) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_f | stall_d),
        .count (hz.StallCount)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_d | flush_e | flush_w),
        .count (hz.FlushCount)
    );

    assign hz.ForwardAE     = fwd_a;
    assign hz.ForwardBE     = fwd_b;
    assign hz.StallF        = stall_f;
    assign hz.StallD        = stall_d;
    assign hz.StallE        = stall_e;
    assign hz.StallM        = stall_m;
    assign hz.FlushD        = flush_d;
    assign hz.FlushE        = flush_e;
    assign hz.FlushW        = flush_w;
    assign hz.MemTimeoutErr = err_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    hazard_controller_if hif ();

    hazard_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [6:0] sf;
    assign sf = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.Match_1E_M = 0; hif.Match_1E_W = 0; hif.Match_2E_M = 0; hif.Match_2E_W = 0;
        hif.Match_12D_E = 0; hif.RegWriteM = 0; hif.RegWriteW = 0; hif.MemtoRegE = 0;
        hif.PCWrPendingF = 0; hif.BranchTakenE = 0; hif.PCSrcW = 0;
        hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hif.Match_1E_M = 1; hif.Match_1E_W = 1; hif.Match_2E_M = 1; hif.Match_2E_W = 1;
        hif.Match_12D_E = 1; hif.RegWriteM = 1; hif.RegWriteW = 1; hif.MemtoRegE = 1;
        hif.PCWrPendingF = 1; hif.BranchTakenE = 1; hif.PCSrcW = 1;
        hif.MemReqM = 1; hif.MemReadyM = 0;
        #1;
        total_cnt++;
        if (sf !== 7'b0) $display("FAIL reset_sf got %b want %b", sf, 7'b0); else pass_cnt++;
        total_cnt++;
        if ({hif.ForwardAE, hif.ForwardBE} !== 4'b0000)
            $display("FAIL reset_fwd got %b want 0000", {hif.ForwardAE, hif.ForwardBE});
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (hif.StallCount !== 16'h0 || hif.FlushCount !== 16'h0 || hif.MemTimeoutErr !== 1'b0)
            $display("FAIL reset_regs got sc=%h fc=%h err=%b want 0 0 0",
                     hif.StallCount, hif.FlushCount, hif.MemTimeoutErr);
        else pass_cnt++;
        clear_inputs();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_forwarding();
        // {M1M, M1W, M2M, M2W, RWM, RWW}, expected {ForwardAE, ForwardBE}
        logic [5:0] vin  [6] = '{6'b110011, 6'b110001, 6'b001111, 6'b000111, 6'b101001, 6'b111110};
        logic [3:0] vexp [6] = '{4'b1000,   4'b0100,   4'b0010,   4'b0001,   4'b0000,   4'b1010};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            {hif.Match_1E_M, hif.Match_1E_W, hif.Match_2E_M, hif.Match_2E_W,
             hif.RegWriteM, hif.RegWriteW} = vin[i];
            #1;
            total_cnt++;
            if ({hif.ForwardAE, hif.ForwardBE} !== vexp[i])
                $display("FAIL fwd_vec%0d got %b want %b", i, {hif.ForwardAE, hif.ForwardBE}, vexp[i]);
            else pass_cnt++;
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_ldr_stall();
        do_reset();
        hif.Match_12D_E = 1; hif.MemtoRegE = 1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            total_cnt++;
            if (sf !== 7'b1100010) $display("FAIL ldr_sf%0d got %b want %b", i, sf, 7'b1100010);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (hif.StallCount !== 16'(i)) $display("FAIL ldr_cnt%0d got %0d want %0d", i, hif.StallCount, i);
            else pass_cnt++;
        end
        clear_inputs();
        tick();
        total_cnt++;
        if (hif.StallCount !== 16'd3 || hif.FlushCount !== 16'd3)
            $display("FAIL ldr_hold got sc=%0d fc=%0d want 3 3", hif.StallCount, hif.FlushCount);
        else pass_cnt++;
    endtask

    task automatic mem_episode(input int cycles, input string tag);
        hif.MemReqM = 1; hif.MemReadyM = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            total_cnt++;
            if (sf !== 7'b1111001) $display("FAIL %s_sf%0d got %b want %b", tag, i, sf, 7'b1111001);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        mem_episode(3, "mem1");
        hif.MemReadyM = 1;
        #1;
        total_cnt++;
        if (sf !== 7'b0) $display("FAIL mem_ready_sf got %b want %b", sf, 7'b0); else pass_cnt++;
        tick();
        total_cnt++;
        if (dut.state_q !== RUN) $display("FAIL mem_state got %0d want RUN", dut.state_q); else pass_cnt++;
        total_cnt++;
        if (hif.StallCount !== 16'd3 || hif.FlushCount !== 16'd3)
            $display("FAIL mem_cnt got sc=%0d fc=%0d want 3 3", hif.StallCount, hif.FlushCount);
        else pass_cnt++;
        mem_episode(3, "mem2");
        hif.MemReadyM = 1;
        tick();
        clear_inputs();
        tick();
        total_cnt++;
        if (hif.MemTimeoutErr !== 1'b0) $display("FAIL mem_noerr got %b want 0", hif.MemTimeoutErr);
        else pass_cnt++;
    endtask

    task automatic test_withdraw();
        do_reset();
        mem_episode(3, "wd1");
        hif.MemReqM = 0;
        tick();
        total_cnt++;
        if (dut.state_q !== RUN) $display("FAIL wd_state got %0d want RUN", dut.state_q); else pass_cnt++;
        mem_episode(3, "wd2");
        hif.MemReadyM = 1;
        tick();
        clear_inputs();
        tick();
        total_cnt++;
        if (hif.MemTimeoutErr !== 1'b0) $display("FAIL wd_noerr got %b want 0", hif.MemTimeoutErr);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        hif.MemReqM = 1; hif.MemReadyM = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total_cnt++;
            if (hif.MemTimeoutErr !== (k >= 5))
                $display("FAIL tmo_edge%0d got %b want %b", k, hif.MemTimeoutErr, (k >= 5));
            else pass_cnt++;
        end
        hif.MemReadyM = 1;
        tick();
        clear_inputs();
        tick();
        tick();
        total_cnt++;
        if (hif.MemTimeoutErr !== 1'b1) $display("FAIL tmo_sticky got %b want 1", hif.MemTimeoutErr);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (hif.MemTimeoutErr !== 1'b0) $display("FAIL tmo_clear got %b want 0", hif.MemTimeoutErr);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        // {MemReqM, LdrStall, BranchTakenE, PCSrcW, PCWrPendingF}, expected sf
        logic [4:0] vin  [6] = '{5'b10110, 5'b11000, 5'b00100, 5'b00001, 5'b01010, 5'b10001};
        logic [6:0] vexp [6] = '{7'b0111001, 7'b1111001, 7'b0000110, 7'b1000100, 7'b0100110, 7'b1111001};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            hif.MemReqM = vin[i][4];
            hif.Match_12D_E = vin[i][3];
            hif.MemtoRegE = vin[i][3];
            hif.BranchTakenE = vin[i][2];
            hif.PCSrcW = vin[i][1];
            hif.PCWrPendingF = vin[i][0];
            #1;
            total_cnt++;
            if (sf !== vexp[i]) $display("FAIL prio_vec%0d got %b want %b", i, sf, vexp[i]);
            else pass_cnt++;
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        hif.Match_12D_E = 1; hif.MemtoRegE = 1;
        repeat (65534) tick();
        total_cnt++;
        if (hif.StallCount !== 16'hFFFE) $display("FAIL sat_pre got %h want FFFE", hif.StallCount);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (hif.StallCount !== 16'hFFFF || hif.FlushCount !== 16'hFFFF)
                $display("FAIL sat_hold%0d got sc=%h fc=%h want FFFF FFFF", i, hif.StallCount, hif.FlushCount);
            else pass_cnt++;
        end
        clear_inputs();
        hif.MemReqM = 1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (sf !== 7'b0) $display("FAIL rst_mid_sf got %b want %b", sf, 7'b0); else pass_cnt++;
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        total_cnt++;
        if (sf !== 7'b0 || dut.state_q !== RUN)
            $display("FAIL rst_mid_after got sf=%b st=%0d want 0 RUN", sf, dut.state_q);
        else pass_cnt++;
        total_cnt++;
        if (hif.StallCount !== 16'h0 || hif.FlushCount !== 16'h0 || hif.MemTimeoutErr !== 1'b0)
            $display("FAIL rst_mid_regs got sc=%h fc=%h err=%b want 0 0 0",
                     hif.StallCount, hif.FlushCount, hif.MemTimeoutErr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (hif.StallCount !== 16'h0) $display("FAIL rst_mid_idle got %h want 0", hif.StallCount);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_ldr_stall();
        test_mem_stall();
        test_withdraw();
        test_timeout();
        test_priority();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum consecutive memory-wait cycles before the timeout error is flagged.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have inputs Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E, 1 bit each: datapath register-address comparisons.
REQ-005 SHALL have inputs RegWriteM, RegWriteW, MemtoRegE, 1 bit each: stage control bits.
REQ-006 SHALL have inputs PCWrPendingF, BranchTakenE, PCSrcW, 1 bit each: PC-redirect indications.
REQ-007 SHALL have inputs MemReqM and MemReadyM, 1 bit each: data-memory request in M and memory completion.
REQ-008 SHALL have outputs ForwardAE and ForwardBE, 2 bits each, with encoding 00 = register file, 01 = ResultW, 10 = ALUOutM.
REQ-009 SHALL have outputs StallF, StallD, StallE, StallM, FlushD, FlushE and FlushW, 1 bit each.
REQ-010 SHALL have output MemTimeoutErr, 1 bit: sticky timeout flag.
REQ-011 SHALL have outputs StallCount and FlushCount, 16 bits each: saturating performance counters.

Function
REQ-012 ForwardAE SHALL be 10 if Match_1E_M & RegWriteM; else 01 if Match_1E_W & RegWriteW; else 00. Forwarding from M takes priority over W.
REQ-013 ForwardBE SHALL follow the same rule as REQ-012 using Match_2E_M and Match_2E_W.
REQ-014 LdrStall SHALL be defined as Match_12D_E & MemtoRegE. It is combinational.
REQ-015 MemStall SHALL be defined as MemReqM & ~MemReadyM. It is combinational.
REQ-016 When MemStall = 1: StallF, StallD, StallE and StallM SHALL be 1, FlushW SHALL be 1 (bubble into W), and FlushD and FlushE SHALL be 0. MemStall dominates LdrStall and BranchTakenE.
REQ-017 When MemStall = 0: StallF = LdrStall | PCWrPendingF; StallD = LdrStall; StallE = StallM = FlushW = 0.
REQ-018 When MemStall = 0: FlushD = PCWrPendingF | PCSrcW | BranchTakenE, and FlushE = LdrStall | BranchTakenE.
REQ-019 PCSrcW = 1 SHALL force StallF = 0 in all cases, including during MemStall, so that the W-stage PC write is never lost.
REQ-020 SHALL implement an FSM with states RUN and MEMWAIT.
REQ-021 In RUN, MemStall SHALL cause a transition to MEMWAIT and load the wait counter with 1; otherwise the FSM remains in RUN.
REQ-022 In MEMWAIT, MemReadyM SHALL cause a transition to RUN and clear the wait counter; otherwise the wait counter SHALL increment, saturating at TIMEOUT_CYCLES.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES, MemTimeoutErr SHALL set on the next edge and remain set until reset. The FSM stays in MEMWAIT.
REQ-024 MemReqM falling without MemReadyM while in MEMWAIT SHALL return the FSM to RUN and clear the wait counter (request withdrawn).
REQ-025 StallCount SHALL increment on every cycle in which StallF | StallD is 1, and SHALL saturate at 16'hFFFF.
REQ-026 FlushCount SHALL increment on every cycle in which FlushD | FlushE | FlushW is 1, and SHALL saturate at 16'hFFFF.
REQ-027 Stall, flush and forward outputs SHALL be combinational with zero-cycle latency. Counters and MemTimeoutErr SHALL update on the clock edge.

Reset
REQ-028 On reset = 1 at a clock edge: FSM = RUN, wait counter = 0, StallCount = 0, FlushCount = 0, MemTimeoutErr = 0.
REQ-029 While reset = 1, all stall and flush outputs SHALL be 0 and ForwardAE = ForwardBE = 00, regardless of other inputs.
REQ-030 Reset asserted mid-MEMWAIT SHALL abandon the wait with no residual stall in the cycle after reset deasserts.

Structure
REQ-031 The FSM state enum (RUN, MEMWAIT) and the forward-select encodings (FWD_RF, FWD_W, FWD_M) SHALL live in a shared package, hazard_pkg.
REQ-032 The saturating 16-bit counter SHALL be one sub-module, sat_counter, instantiated for StallCount and FlushCount.
REQ-033 Forward and stall/flush logic SHALL be purely combinational, with no added pipeline registers.

Verification
REQ-034 Match_1E_M = 1, RegWriteM = 1, Match_1E_W = 1, RegWriteW = 1 -> ForwardAE = 10; with RegWriteM = 0 instead -> ForwardAE = 01.
REQ-035 Match_12D_E = 1, MemtoRegE = 1, no other events -> StallF = 1, StallD = 1, FlushE = 1, FlushD = 0; StallCount increments by 1 per cycle.
REQ-036 MemReqM = 1, MemReadyM = 0 for 3 cycles, then MemReadyM = 1 -> StallF/D/E/M = 1 and FlushW = 1 for exactly 3 cycles; FSM returns to RUN; MemTimeoutErr = 0.
REQ-037 Set TIMEOUT_CYCLES = 4 and hold MemStall for 6 cycles -> MemTimeoutErr rises after the 4th wait cycle and stays 1 after MemReadyM arrives, until reset.
REQ-038 MemStall = 1 with BranchTakenE = 1 and PCSrcW = 1 -> FlushE = 0, FlushD = 0, StallF = 0, StallD = 1.
REQ-039 Preload StallCount = 16'hFFFE and hold LdrStall for 3 cycles -> StallCount reads 16'hFFFF and holds; assert reset mid-MEMWAIT -> all counters = 0 and FSM = RUN next cycle.
